// File: rtl/rv32_pipeline_pkg.sv
// rtl/rv32_pipeline_pkg.sv - shared pipeline types, LSU state and funct3 decode helpers
package rv32_pipeline_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_RESP = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_t;

    localparam logic [2:0] LSU_F3_B  = 3'b000;
    localparam logic [2:0] LSU_F3_H  = 3'b001;
    localparam logic [2:0] LSU_F3_W  = 3'b010;
    localparam logic [2:0] LSU_F3_BU = 3'b100;
    localparam logic [2:0] LSU_F3_HU = 3'b101;

    localparam int unsigned LSU_TIMEOUT_DEFAULT = 16;

    // Loads allow 000,001,010,100,101; stores only 000..010.
    function automatic logic lsu_f3_illegal(input logic we, input logic [2:0] f3);
        if (we) begin
            return f3 > LSU_F3_W;
        end
        return (f3 == 3'b011) || (f3[2:1] == 2'b11);
    endfunction

    function automatic logic lsu_f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            LSU_F3_H, LSU_F3_HU: return off[0];
            LSU_F3_W:            return off != 2'b00;
            default:             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv32_load_store_unit_if.sv
// rtl/rv32_load_store_unit_if.sv - word-addressed data bus with request/grant/response handshake
// master: LSU side (drives bus_req/bus_we/bus_addr/bus_be/bus_wdata)
// slave : memory side (drives bus_gnt/bus_rvalid/bus_rdata/bus_err)
interface rv32_load_store_unit_if;
    import rv32_pipeline_pkg::*;

    logic        bus_req;
    logic        bus_we;
    word_t       bus_addr;
    logic [3:0]  bus_be;
    word_t       bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    word_t       bus_rdata;
    logic        bus_err;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata, bus_err
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata, bus_err
    );
endinterface

// File: rtl/rv32_lsu_lane_align.sv
// rtl/rv32_lsu_lane_align.sv - byte-enable, store replication and load extraction (combinational)
// i_funct3 : access size / signedness
// i_offset : byte offset addr[1:0]
// i_wdata  : raw store data (rs2)
// i_rdata  : raw bus read word
// o_be     : byte enables
// o_wdata  : lane-replicated store data
// o_rdata  : shifted and sign/zero-extended load data
module rv32_lsu_lane_align
    import rv32_pipeline_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic [1:0] i_offset,
    input  word_t      i_wdata,
    input  word_t      i_rdata,
    output logic [3:0] o_be,
    output word_t      o_wdata,
    output word_t      o_rdata
);
    word_t w_shifted;

    // Addressed byte/halfword lands in the low lanes.
    assign w_shifted = i_rdata >> {i_offset, 3'b000};

    always_comb begin
        o_be    = 4'b0000;
        o_wdata = i_wdata;
        o_rdata = w_shifted;
        case (i_funct3)
            LSU_F3_B: begin
                o_be    = 4'b0001 << i_offset;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{w_shifted[7]}}, w_shifted[7:0]};
            end
            LSU_F3_BU: begin
                o_be    = 4'b0001 << i_offset;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {24'h000000, w_shifted[7:0]};
            end
            LSU_F3_H: begin
                o_be    = i_offset[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = {{16{w_shifted[15]}}, w_shifted[15:0]};
            end
            LSU_F3_HU: begin
                o_be    = i_offset[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = {16'h0000, w_shifted[15:0]};
            end
            LSU_F3_W: begin
                o_be    = 4'b1111;
            end
            default: begin
                o_be    = 4'b0000;
            end
        endcase
    end
endmodule

// File: rtl/rv32_load_store_unit.sv
// rtl/rv32_load_store_unit.sv - multicycle RV32I load/store unit, one outstanding bus access
// clk, rst_n        : clock, async active-low reset
// lsu_req/we/funct3/addr/wdata : MEM-stage access, held stable while lsu_stall
// lsu_stall         : freeze pipeline
// lsu_rvalid        : one-cycle completion pulse
// lsu_rdata         : extended load data (updated only by a successful load)
// lsu_misaligned    : with lsu_rvalid, address not aligned to size
// lsu_fault         : with lsu_rvalid, illegal funct3, bus error or timeout
// bus               : data bus master port
module rv32_load_store_unit
    import rv32_pipeline_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lsu_req,
    input  logic       lsu_we,
    input  logic [2:0] lsu_funct3,
    input  word_t      lsu_addr,
    input  word_t      lsu_wdata,
    output logic       lsu_stall,
    output logic       lsu_rvalid,
    output word_t      lsu_rdata,
    output logic       lsu_misaligned,
    output logic       lsu_fault,
    rv32_load_store_unit_if.master bus
);
    // Last REQ/RESP cycle count before the access is abandoned.
    localparam logic [7:0] L_TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    lsu_state_t r_state;
    logic [7:0] r_cnt;
    logic       r_bus_req;
    logic       r_bus_we;
    word_t      r_bus_addr;
    logic [3:0] r_bus_be;
    word_t      r_bus_wdata;
    logic       r_rvalid;
    word_t      r_rdata;
    logic       r_misaligned;
    logic       r_fault;

    logic [3:0] w_be;
    word_t      w_wdata_rep;
    word_t      w_rdata_ext;
    logic       w_illegal;
    logic       w_misaligned;
    logic       w_timeout;

    // MEM-stage inputs stay stable through RESP, so one aligner serves
    // both the request fields and the response extraction.
    rv32_lsu_lane_align u_align (
        .i_funct3 (lsu_funct3),
        .i_offset (lsu_addr[1:0]),
        .i_wdata  (lsu_wdata),
        .i_rdata  (bus.bus_rdata),
        .o_be     (w_be),
        .o_wdata  (w_wdata_rep),
        .o_rdata  (w_rdata_ext)
    );

    assign w_illegal    = lsu_f3_illegal(lsu_we, lsu_funct3);
    assign w_misaligned = lsu_f3_misaligned(lsu_funct3, lsu_addr[1:0]);
    assign w_timeout    = (r_cnt == L_TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= LSU_IDLE;
            r_cnt        <= 8'd0;
            r_bus_req    <= 1'b0;
            r_bus_we     <= 1'b0;
            r_bus_addr   <= '0;
            r_bus_be     <= 4'b0000;
            r_bus_wdata  <= '0;
            r_rvalid     <= 1'b0;
            r_rdata      <= '0;
            r_misaligned <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            case (r_state)
                LSU_IDLE: begin
                    if (lsu_req) begin
                        if (w_illegal) begin
                            r_state  <= LSU_DONE;
                            r_rvalid <= 1'b1;
                            r_fault  <= 1'b1;
                        end else if (w_misaligned) begin
                            r_state      <= LSU_DONE;
                            r_rvalid     <= 1'b1;
                            r_misaligned <= 1'b1;
                        end else begin
                            r_state     <= LSU_REQ;
                            r_cnt       <= 8'd0;
                            r_bus_req   <= 1'b1;
                            r_bus_we    <= lsu_we;
                            r_bus_addr  <= {lsu_addr[31:2], 2'b00};
                            r_bus_be    <= w_be;
                            r_bus_wdata <= w_wdata_rep;
                        end
                    end
                end
                LSU_REQ: begin
                    // A grant on the final budgeted cycle loses to the timeout;
                    // its late response is dropped since rvalid only counts in RESP.
                    if (w_timeout) begin
                        r_state   <= LSU_DONE;
                        r_bus_req <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_fault   <= 1'b1;
                    end else if (bus.bus_gnt) begin
                        r_state   <= LSU_RESP;
                        r_bus_req <= 1'b0;
                        r_cnt     <= r_cnt + 8'd1;
                    end else begin
                        r_cnt     <= r_cnt + 8'd1;
                    end
                end
                LSU_RESP: begin
                    // Response takes precedence over a coincident timeout.
                    if (bus.bus_rvalid) begin
                        r_state  <= LSU_DONE;
                        r_rvalid <= 1'b1;
                        r_fault  <= bus.bus_err;
                        if (!r_bus_we && !bus.bus_err) begin
                            r_rdata <= w_rdata_ext;
                        end
                    end else if (w_timeout) begin
                        r_state  <= LSU_DONE;
                        r_rvalid <= 1'b1;
                        r_fault  <= 1'b1;
                    end else begin
                        r_cnt    <= r_cnt + 8'd1;
                    end
                end
                LSU_DONE: begin
                    // The request visible here is the one completing; never re-accept it.
                    r_state      <= LSU_IDLE;
                    r_rvalid     <= 1'b0;
                    r_misaligned <= 1'b0;
                    r_fault      <= 1'b0;
                end
                default: begin
                    r_state <= LSU_IDLE;
                end
            endcase
        end
    end

    // rst_n gating makes the stall drop immediately on reset even if the
    // MEM stage still presents a request.
    assign lsu_stall = rst_n & (((r_state == LSU_IDLE) & lsu_req) |
                                (r_state == LSU_REQ) | (r_state == LSU_RESP));

    assign lsu_rvalid     = r_rvalid;
    assign lsu_rdata      = r_rdata;
    assign lsu_misaligned = r_misaligned;
    assign lsu_fault      = r_fault;

    assign bus.bus_req   = r_bus_req;
    assign bus.bus_we    = r_bus_we;
    assign bus.bus_addr  = r_bus_addr;
    assign bus.bus_be    = r_bus_be;
    assign bus.bus_wdata = r_bus_wdata;
endmodule

// File: doc/rv32_load_store_unit.md
# rv32_load_store_unit

Multicycle load/store unit between the pipeline's MEM stage and a word-addressed data bus with a request/grant/response handshake. It decodes the access size from funct3, generates byte enables and replicated store data, and returns sign- or zero-extended load data. It holds the pipeline with `lsu_stall` until the access completes, and reports misalignment, illegal size, bus error or timeout. One outstanding transaction at a time.

## Interface
- `TIMEOUT_CYCLES`, default 16: cycles allowed in REQ+RESP combined before abort with fault; range 2..255.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `lsu_req` in 1: MEM stage holds a load/store; held stable with all `lsu_*` inputs while `lsu_stall`=1.
- `lsu_we` in 1: 1 = store, 0 = load.
- `lsu_funct3` in 3: RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
- `lsu_addr` in 32: byte address (ALU result).
- `lsu_wdata` in 32: rs2 store data.
- `lsu_stall` out 1: freeze pipeline.
- `lsu_rvalid` out 1: one-cycle pulse, access finished (any outcome).
- `lsu_rdata` out 32: extended load data, valid with `lsu_rvalid` on a successful load.
- `lsu_misaligned` out 1: with `lsu_rvalid`, address misaligned for size.
- `lsu_fault` out 1: with `lsu_rvalid`, illegal funct3, bus error or timeout.
- `bus_req` out 1: request; held with fields stable until `bus_gnt`.
- `bus_we` out 1: write.
- `bus_addr` out 32: `{lsu_addr[31:2],2'b00}`.
- `bus_be` out 4: byte enables.
- `bus_wdata` out 32: lane-replicated store data.
- `bus_gnt` in 1: request accepted this cycle.
- `bus_rvalid` in 1: response (read data or write ack), earliest one cycle after `bus_gnt`.
- `bus_rdata` in 32: read data, valid with `bus_rvalid`.
- `bus_err` in 1: error, sampled only with `bus_rvalid`.

## Operation
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE, `lsu_req`=1: legal and aligned -> REQ, load bus registers; misaligned -> DONE with misaligned flag; illegal funct3 -> DONE with fault flag. No bus activity on the error paths.
- Illegal funct3: loads 011, 110, 111; stores anything above 010.
- Misaligned: halfword with `addr[0]`=1; word with `addr[1:0]`≠0. Illegal funct3 takes priority over misaligned.
- REQ: `bus_req`=1. On `bus_gnt` -> RESP and drop `bus_req`.
- RESP: on `bus_rvalid` -> DONE. Capture `bus_err` into fault. On a load without error, capture extracted data.
- DONE: `lsu_rvalid`=1, flags driven, `lsu_stall`=0 -> IDLE.
- Timeout counter clears on entering REQ and increments each cycle in REQ/RESP. At `TIMEOUT_CYCLES` -> DONE with fault and `bus_req` dropped. `bus_rvalid` is ignored outside RESP.
- Byte lanes, with `o=addr[1:0]`:
  - B: `be=4'b0001<<o`, `wdata={4{wdata[7:0]}}`.
  - H: `be=addr[1]?4'b1100:4'b0011`, `wdata={2{wdata[15:0]}}`.
  - W: `be=4'b1111`.
  - Loads use the same `be`.
- Load extraction: `bus_rdata>>(8*o)`, then sign-extend for LB/LH and zero-extend for LBU/LHU/LW.
- `lsu_rdata` holds its last value except on a successful-load capture; stores leave it unchanged.

## Timing
- All outputs reset to 0; FSM resets to IDLE; counter resets to 0.
- `lsu_stall` = (IDLE & `lsu_req`) | REQ | RESP. It is combinational from `lsu_req` in IDLE.
- Zero-wait bus (grant in the REQ cycle, rvalid the next cycle): IDLE, REQ, RESP, DONE. That is 3 stall cycles, with the pipeline advancing on the DONE edge.
- Error paths (misaligned or illegal funct3): IDLE, DONE, giving 1 stall cycle.
- The request seen in DONE is the completing one and is never re-accepted; a new request is seen in the following IDLE.
- `bus_gnt` in the first REQ cycle is legal. `bus_gnt` and `bus_rvalid` in the same cycle is illegal; the bench asserts against it.
- Timeout and `bus_rvalid` in the same cycle: the response wins.
- Reset mid-transaction: `bus_req` and `lsu_stall` drop asynchronously and no `lsu_rvalid` is produced.

## Structure
- Add to `rv32_pipeline_pkg`:
  - `lsu_state_t` enum.
  - `LSU_F3_B/H/W/BU/HU` constants.
  - `LSU_TIMEOUT_DEFAULT`.
  - `word_t` reused for all 32-bit ports.
- Sub-module `rv32_lsu_lane_align`: purely combinational. Inputs are funct3, `addr[1:0]`, wdata and rdata; outputs are `be`, replicated wdata and extended rdata.

## Test plan
- SB at 0x1003, data 0x000000A5, gnt and rvalid zero-wait -> `bus_addr`=0x1000, `be`=1000, `wdata`=0xA5A5A5A5; `lsu_rvalid` 3 cycles after `lsu_req` with no flags.
- LB at 0x2002, `bus_rdata`=0x00F00000 -> `lsu_rdata`=0xFFFFFFF0. LBU with the same stimulus -> 0x000000F0.
- LW at 0x3002 -> no `bus_req`; `lsu_rvalid`+`lsu_misaligned` the next cycle, with 1 stall cycle.
- LH at 0x4000, `bus_gnt` delayed 3 cycles and `bus_err`=1 with `bus_rvalid` -> `lsu_fault`=1; `lsu_rdata` unchanged.
- LW with no `bus_gnt` and `TIMEOUT_CYCLES`=16 -> `bus_req` high for 16 cycles, then `lsu_fault` pulse. A later stray `bus_rvalid` in IDLE is ignored.
- `rst_n` low while in RESP -> `bus_req` and `lsu_stall` 0 immediately, with no `lsu_rvalid` after release.
